// File: rtl/ring_pkg.sv
// Shared ring definitions: ring geometry constants and the loader request record.
// Used by ring_byte_loader, its request FIFO, the ring itself and their benches.
package ring_pkg;

    localparam int unsigned RING_WORD_COUNT = 22;
    localparam int unsigned BITS_PER_WORD   = 8;
    localparam int unsigned RING_SLOT_W     = $clog2(RING_WORD_COUNT);

    typedef struct packed {
        logic [RING_SLOT_W-1:0]   slot;
        logic [BITS_PER_WORD-1:0] data;
        logic                     fill;
    } ring_req_t;

endpackage

// File: rtl/ring_req_fifo.sv
// Synchronous request FIFO for the ring loader: registered occupancy, sync active-high reset.
// Pushes while full and pops while empty are ignored.
module ring_req_fifo
    import ring_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  ring_req_t wdata,
    input  logic      pop,
    output ring_req_t rdata,
    output logic      empty,
    output logic      full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ring_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ring_byte_loader.sv
// Host-side writer for the rotating byte ring: queues (slot, byte) requests and serialises each
// into write/din while its slot is in the write window. RING_LOADER_FILL_EN adds whole-ring fill.
module ring_byte_loader
    import ring_pkg::*;
#(
    parameter int unsigned WORD_COUNT = RING_WORD_COUNT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SLOT_W     = $clog2(WORD_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic [7:0]        in_data,
`ifdef RING_LOADER_FILL_EN
    input  logic              in_fill,
`endif
    output logic              ring_write,
    output logic              ring_din,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [2:0]        phase_q;
    logic [SLOT_W-1:0] head_q;
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              write_d;
    logic              din_d;
    ring_req_t         req_in;
    ring_req_t         req_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              slot_ok;
    logic              start;
    logic              frame_done;
    logic              last_bit;

    assign in_ready = !fifo_full && !reset;
    assign slot_ok  = 32'(in_slot) < WORD_COUNT;

    always_comb begin
        req_in      = '0;
        req_in.slot = RING_SLOT_W'(in_slot);
        req_in.data = in_data;
`ifdef RING_LOADER_FILL_EN
        req_in.fill = in_fill;
`endif
    end

    // Out-of-range slots are accepted but never queued, so they can never transmit.
    assign fifo_push = in_valid && in_ready && (slot_ok || req_in.fill);
    assign fifo_pop  = last_bit;

    ring_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (req_in),
        .pop   (fifo_pop),
        .rdata (req_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Lock-step mirror of the ring: phase/head name the bit registered at the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 3'd1;
            head_q  <= '0;
        end else begin
            phase_q <= phase_q + 3'd1;
            if (phase_q == 3'd7) begin
                head_q <= (head_q == SLOT_W'(WORD_COUNT - 1)) ? '0 : head_q + SLOT_W'(1);
            end
        end
    end

`ifdef RING_LOADER_FILL_EN
    logic [SLOT_W-1:0] frame_q;

    assign start = (state_q == ST_IDLE) && !fifo_empty && (phase_q == 3'd0) &&
                   (req_head.fill || (SLOT_W'(req_head.slot) == head_q));
    assign frame_done = !req_head.fill || (frame_q == SLOT_W'(WORD_COUNT - 1));

    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_IDLE)) begin
            frame_q <= '0;
        end else if (phase_q == 3'd7) begin
            frame_q <= frame_q + SLOT_W'(1);
        end
    end
`else
    logic unused_fill;

    assign unused_fill = req_head.fill;
    assign start = (state_q == ST_IDLE) && !fifo_empty && (phase_q == 3'd0) &&
                   (SLOT_W'(req_head.slot) == head_q);
    assign frame_done = 1'b1;
`endif

    assign last_bit = (state_q == ST_SEND) && (phase_q == 3'd7) && frame_done;

    always_comb begin
        state_d = state_q;
        write_d = 1'b0;
        din_d   = 1'b0;
        if (start) begin
            state_d = ST_SEND;
            write_d = 1'b1;
            din_d   = req_head.data[phase_q];
        end else if (state_q == ST_SEND) begin
            write_d = 1'b1;
            din_d   = req_head.data[phase_q];
            if (last_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ring_write <= 1'b0;
            ring_din   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_write <= write_d;
            ring_din   <= din_d;
        end
    end

    // ring_write covers the final bit still on the pins after the pop.
    assign busy = !fifo_empty || (state_q == ST_SEND) || ring_write;

endmodule

// File: doc/ring_byte_loader.md
# ring_byte_loader

Host-side writer for the 22-slot rotating byte ring: accepts (slot, byte) write requests over a valid/ready port, queues them, and serialises each into the ring's `write`/`din` pins during the 8-clock frame in which the addressed slot sits in the ring's write window. It sits in front of the ring, shares its `clk` and `reset`, and keeps a lock-step mirror of the ring's bit counter and slot rotation, so no handshake back from the ring is needed.

## Interface
- `WORD_COUNT`, 22: slots in the ring; must match the ring instance.
- `FIFO_DEPTH`, 4: queued requests; power of two, ≥2.
- `SLOT_W`, $clog2(WORD_COUNT): slot index width.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; must be the same `reset` net the ring sees.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO not full; reset 0 during `reset`, 1 afterwards.
- `in_slot` in SLOT_W: target slot, 0..WORD_COUNT-1.
- `in_data` in 8: byte to write.
- `ring_write` out 1: drives the ring's `write` pin; reset 0.
- `ring_din` out 1: drives the ring's `din` pin; reset 0.
- `busy` out 1: FIFO non-empty or frame in flight; reset 0.
- `in_fill` in 1: only with `RING_LOADER_FILL_EN`.

## Operation
- Mirror state:
  - `phase` (3 bits) is the bit index the outputs present in the next cycle; it resets to 1 and increments mod 8 every cycle.
  - `head` (SLOT_W) is the slot owning that bit; it resets to 0 and increments mod WORD_COUNT each time a bit with `phase==7` is presented.
- Slot 0 is defined as the byte in the ring's write window during the first frame after reset.
- Request queue:
  - Accept on `in_valid & in_ready`.
  - `in_slot ≥ WORD_COUNT` is accepted and dropped; it never transmits.
- FSM:
  - IDLE → SEND when the FIFO head's slot equals `head` and `phase==0`.
  - In SEND, each cycle register `ring_write=1` and `ring_din=data[phase]` (LSB first) for phases 0..7, then pop and return to IDLE.
  - Back-to-back frames are permitted with no gap when the next entry targets `head+1`.
  - In IDLE, `ring_write=0` and `ring_din=0`.
- Ordering:
  - Strictly FIFO; no reordering.
  - A head-of-line request waits up to one full revolution (8·WORD_COUNT cycles) for its slot.
- Same-cycle push and pop when full: a pop frees space, but `in_ready` is computed from registered occupancy, so no push is accepted that cycle.
- Reset mid-frame: the frame is abandoned, the FIFO is cleared and outputs go to 0. The ring resets its counter in the same cycle, so alignment is preserved.

## Timing
- Outputs are registered.
- The value presented in the cycle after edge n is sampled by the ring at edge n+1 with ring count = (n+1) mod 8.
- Frame 0 / slot 0 of the first revolution is unwritable, because the outputs are still at reset values.
- Minimum latency: acceptance at edge t gives first `ring_write=1` at edge t+1, when the slot window opens then. Maximum latency: t+1+8·WORD_COUNT plus queue wait.
- `busy` falls in the cycle after the last bit of the last entry is presented.
- `in_ready` is combinational from registered occupancy only; there is no path from `in_valid`.

## Configuration
- `RING_LOADER_FILL_EN` defined:
  - Adds the `in_fill` port and stores a fill flag per FIFO entry.
  - A fill entry ignores `in_slot`, waits for `phase==0`, then transmits `in_data` for WORD_COUNT consecutive frames (8·WORD_COUNT cycles, `ring_write` held 1) before popping.
- Undefined: no port, no flag storage; every entry is a single-slot write.

## Structure
- Shared package `ring_pkg`:
  - `RING_WORD_COUNT` (22) and `BITS_PER_WORD` (8) constants.
  - `ring_req_t` struct {slot, data, fill}.
  - Shared with the ring and its bench.
- One sub-module, `ring_req_fifo`: synchronous FIFO of `ring_req_t`, parameter DEPTH, registered occupancy, sync active-high reset.
- Mirror counters, FSM and output registers live in `ring_byte_loader`.

## Test plan
- Reset, push slot 3 / 0xA5 → `ring_write` high for exactly 8 cycles beginning when `head==3` and `phase==0`. Bits presented are 1,0,1,0,0,1,0,1. The ring model then shows 0xA5 in slot 3 while the other slots are unchanged.
- Push slots 5, 6, 7 back-to-back → three contiguous frames, 24 cycles of `ring_write=1`, no gap.
- Push 5 requests with depth 4 and the ring stalled on a far slot → `in_ready=0` after 4, the 5th is held, and all 5 bytes land in order.
- Assert `reset` on the 4th bit of a frame → outputs 0 the next cycle, FIFO empty, `busy=0`. A new write to slot 2 after reset lands correctly.
- Push slot 22 / 0xFF → accepted, no `ring_write` pulse, `busy` clears within 2 cycles.
- With `RING_LOADER_FILL_EN`, fill 0x3C → 176 cycles of `ring_write=1`, after which every ring slot reads 0x3C.
